// File: rtl/pbus_target_if.sv
// PBus target-side bundle: request/command from the initiator, grant/rdata
// (and err when PBUS_TGT_ERR_EN is defined) back from the target.
//
// Handshake: the initiator raises req with we/addr/wdata and holds req until
// it sees grant=1 for one cycle; the target samples the command only on the
// edge where it accepts req from idle. After grant, req must go low for at
// least one cycle before the next request is recognised. rdata is valid only
// while grant=1.
interface pbus_target_if #(
  parameter int WIDTH = 8
);
  logic             req;
  logic             we;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] wdata;
  logic             grant;
  logic [WIDTH-1:0] rdata;
`ifdef PBUS_TGT_ERR_EN
  logic             err;

  modport master (output req, we, addr, wdata, input grant, rdata, err);
  modport slave  (input req, we, addr, wdata, output grant, rdata, err);
`else
  modport master (output req, we, addr, wdata, input grant, rdata);
  modport slave  (input req, we, addr, wdata, output grant, rdata);
`endif
endinterface

// File: rtl/pbus_target.sv
// PBus target: accepts one request at a time, inserts WAIT_CYCLES wait
// states, answers with a one-cycle grant and services the access against an
// internal DEPTH-entry register file.
// Optional feature macro: PBUS_TGT_ERR_EN -- adds the err strobe and flags
// out-of-range addresses (write suppressed, rdata 0). Without it the address
// wraps onto entry addr mod DEPTH.
module pbus_target #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  pbus_target_if.slave bus,
  output logic [1:0]   dbg_state
);

  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_GRANT = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  // Wait counter load value; unused when there are no wait states.
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             grant_q, grant_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [IDX_W-1:0] idx;

  assign idx = addr_q[IDX_W-1:0];

`ifdef PBUS_TGT_ERR_EN
  logic err_q, err_d;
  logic addr_oob;
  // Widen by one bit so DEPTH == 2**WIDTH never reports out of range.
  assign addr_oob = ({1'b0, addr_q} >= (WIDTH + 1)'(DEPTH));
`else
  // Upper address bits only matter for the range check; here they wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_q;
`endif

  // Next-state, command latch, register-file update and response generation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    grant_d = 1'b0;
    rdata_d = '0;
    mem_d   = mem_q;
`ifdef PBUS_TGT_ERR_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_GRANT;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        // Dropping req during the wait states abandons the access untouched.
        if (!bus.req) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_GRANT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_GRANT: begin
        grant_d = 1'b1;
        state_d = ST_HOLD;
`ifdef PBUS_TGT_ERR_EN
        if (addr_oob) err_d = 1'b1;
        else
`endif
        if (we_q) mem_d[idx] = wdata_q;
        else      rdata_d    = mem_q[idx];
      end
      ST_HOLD: begin
        // A held req must not re-trigger; wait for it to drop.
        if (!bus.req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and register file, cleared asynchronously on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      grant_q <= 1'b0;
      rdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
`ifdef PBUS_TGT_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      grant_q <= grant_d;
      rdata_q <= rdata_d;
      mem_q   <= mem_d;
`ifdef PBUS_TGT_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  assign bus.grant = grant_q;
  assign bus.rdata = rdata_q;
`ifdef PBUS_TGT_ERR_EN
  assign bus.err   = err_q;
`endif
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pbus_target.sv
// Bench for pbus_target: one instance with two wait states and one with none,
// driven by directed scenarios then random traffic, checked against a
// transaction-level register-file model.
module tb_pbus_target;

  localparam int W   = 8;
  localparam int D   = 16;
  localparam int WC0 = 2;
  localparam int WC1 = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         req_v   [2];
  logic         we_v    [2];
  logic [W-1:0] addr_v  [2];
  logic [W-1:0] wdata_v [2];
  logic [1:0]   st0, st1;

  pbus_target_if #(.WIDTH(W)) bus0 ();
  pbus_target_if #(.WIDTH(W)) bus1 ();

  assign bus0.req   = req_v[0];
  assign bus0.we    = we_v[0];
  assign bus0.addr  = addr_v[0];
  assign bus0.wdata = wdata_v[0];
  assign bus1.req   = req_v[1];
  assign bus1.we    = we_v[1];
  assign bus1.addr  = addr_v[1];
  assign bus1.wdata = wdata_v[1];

  pbus_target #(.WIDTH(W), .DEPTH(D), .WAIT_CYCLES(WC0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .dbg_state(st0)
  );
  pbus_target #(.WIDTH(W), .DEPTH(D), .WAIT_CYCLES(WC1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .dbg_state(st1)
  );

  // ---------------- scoreboard ----------------
  int vec_cnt = 0;
  int err_cnt = 0;
  logic [W-1:0] model_mem [2][D];
  logic [W-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic grant_of(input int s);
    return (s == 0) ? bus0.grant : bus1.grant;
  endfunction

  function automatic logic [W-1:0] rdata_of(input int s);
    return (s == 0) ? bus0.rdata : bus1.rdata;
  endfunction

  function automatic int wc_of(input int s);
    return (s == 0) ? WC0 : WC1;
  endfunction

`ifdef PBUS_TGT_ERR_EN
  function automatic logic err_of(input int s);
    return (s == 0) ? bus0.err : bus1.err;
  endfunction
`endif

  function automatic bit model_oob(input logic [W-1:0] a);
`ifdef PBUS_TGT_ERR_EN
    return (int'(a) >= D);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_clear();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < D; i++) model_mem[s][i] = '0;
  endtask

  task automatic check_idle_outputs(input string tag, input int s);
    check({tag, "_grant"}, grant_of(s), 1'b0);
    check({tag, "_rdata"}, rdata_of(s), '0);
`ifdef PBUS_TGT_ERR_EN
    check({tag, "_err"}, err_of(s), 1'b0);
`endif
  endtask

  // ---------------- driver tasks ----------------
  // Full transaction: request, wait for grant, check it, hold req, release.
  task automatic access(input int s, input logic w, input logic [W-1:0] a,
                        input logic [W-1:0] d, input int hold);
    logic [W-1:0] exp_rd;
    logic [W-1:0] exp_pop;
    bit oob;
    bit seen;
    int k;
    oob    = model_oob(a);
    exp_rd = '0;
    if (!oob) begin
      if (w) model_mem[s][int'(a) % D] = d;
      else   exp_rd = model_mem[s][int'(a) % D];
    end
    exp_q.push_back(exp_rd);
    @(negedge clk);
    req_v[s] = 1'b1; we_v[s] = w; addr_v[s] = a; wdata_v[s] = d;
    @(posedge clk);                       // command sampled here
    #1;
    we_v[s] = 1'($urandom); addr_v[s] = W'($urandom); wdata_v[s] = W'($urandom);
    seen = 1'b0;
    k = 0;
    while (!seen && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (grant_of(s)) seen = 1'b1;
    end
    exp_pop = exp_q.pop_front();
    check("grant_seen", seen, 1'b1);
    if (seen) begin
      check("grant_latency", k, wc_of(s) + 1);
      check("rdata", rdata_of(s), exp_pop);
`ifdef PBUS_TGT_ERR_EN
      check("err", err_of(s), oob);
`endif
    end
    for (int h = 0; h <= hold; h++) begin
      @(posedge clk); #1;
      check_idle_outputs("hold", s);
    end
    @(negedge clk);
    req_v[s] = 1'b0;
    @(posedge clk);
  endtask

  // Request on the wait-state instance that is withdrawn during WAIT.
  task automatic abort_access(input logic w, input logic [W-1:0] a,
                              input logic [W-1:0] d, input int dly);
    @(negedge clk);
    req_v[0] = 1'b1; we_v[0] = w; addr_v[0] = a; wdata_v[0] = d;
    @(posedge clk);
    repeat (dly - 1) @(posedge clk);
    @(negedge clk);
    req_v[0] = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      check("abort_no_grant", grant_of(0), 1'b0);
    end
  endtask

  task automatic release_reset();
    for (int s = 0; s < 2; s++) req_v[s] = 1'b0;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int s = 0; s < 2; s++) begin
      req_v[s] = 1'b0; we_v[s] = 1'b0; addr_v[s] = '0; wdata_v[s] = '0;
    end
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset0", 0);
    check_idle_outputs("reset1", 1);
    release_reset();

    // Write then read back with two wait states.
    access(0, 1'b1, 8'h03, 8'hA5, 0);
    access(0, 1'b0, 8'h03, 8'h00, 0);
    // Zero wait states, read of a cleared entry.
    access(1, 1'b0, 8'h05, 8'h00, 0);
    // Aborted write leaves the entry untouched.
    abort_access(1'b1, 8'h01, 8'h3C, 1);
    access(0, 1'b0, 8'h01, 8'h00, 0);
    abort_access(1'b1, 8'h02, 8'h4D, 2);
    access(0, 1'b0, 8'h02, 8'h00, 0);
    // Held req gives one grant only; a fresh request gives another.
    access(0, 1'b1, 8'h04, 8'h11, 10);
    access(0, 1'b0, 8'h04, 8'h00, 10);
    access(1, 1'b1, 8'h06, 8'h22, 10);
    access(1, 1'b0, 8'h06, 8'h00, 0);
    // Out-of-range / wrapping address.
    access(0, 1'b1, 8'h13, 8'h77, 0);
    access(0, 1'b0, 8'h03, 8'h00, 0);
    access(1, 1'b1, 8'hF3, 8'h66, 0);
    access(1, 1'b0, 8'h03, 8'h00, 0);
    access(1, 1'b0, 8'h13, 8'h00, 0);

    // Reset during WAIT.
    access(0, 1'b1, 8'h07, 8'h55, 0);
    @(negedge clk);
    req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 8'h08; wdata_v[0] = 8'h99;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_idle_outputs("rst_wait", 0);
    release_reset();
    access(0, 1'b0, 8'h07, 8'h00, 0);
    access(0, 1'b0, 8'h08, 8'h00, 0);

    // Reset while grant is showing read data.
    access(0, 1'b1, 8'h09, 8'h5A, 0);
    @(negedge clk);
    req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 8'h09;
    begin
      int k;
      k = 0;
      while (!grant_of(0) && k < 40) begin
        @(posedge clk); #1;
        k++;
      end
      check("rst_grant_seen", grant_of(0), 1'b1);
      check("rst_grant_rdata", rdata_of(0), 8'h5A);
    end
    rst = 1'b1;
    #1;
    check_idle_outputs("rst_grant", 0);
    release_reset();
    access(0, 1'b0, 8'h09, 8'h00, 0);
    access(0, 1'b1, 8'h09, 8'hC3, 0);
    access(0, 1'b0, 8'h09, 8'h00, 0);

    // Random traffic on both instances.
    for (int n = 0; n < 80; n++) begin
      int s;
      int op;
      logic [W-1:0] a;
      s  = $urandom_range(0, 1);
      op = $urandom_range(0, 9);
      a  = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, D - 1)) : W'($urandom);
      if (s == 0 && op == 0)
        abort_access(1'($urandom), a, W'($urandom), $urandom_range(1, WC0));
      else
        access(s, (op < 5), a, W'($urandom), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  // Overall time bound so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    err_cnt++;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $fatal(1, "watchdog expired");
  end

endmodule
